// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_XLEN = 32;

    // Special-case results for divide-by-zero and signed overflow
    localparam logic [MD_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [MD_XLEN-1:0] INT_MIN  = 32'h8000_0000;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Datapath: 64-bit accumulator doing one shift-add (multiply) or one
// restoring-subtract (divide) step per cycle on unsigned magnitudes.
// Multiply: acc starts as {0, multiplier}; the low half drains out as the
// product shifts in. Divide: acc starts as {0, dividend}; the high half holds
// the partial remainder and the low half collects quotient bits.
module muldiv_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0]   opnd;
    logic              div_mode;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;

    // Next accumulator value: initial load or one iteration step
    always_comb begin
        acc_next = acc;
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = {1'b0, rem_sh} - {2'b00, opnd};
        if (load) begin
            acc_next = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        end else if (step) begin
            if (div_mode) begin
                // Keep the difference only when it did not go negative
                if (!diff[XLEN+1]) begin
                    acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                end else begin
                    acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_next = {sum, acc[XLEN-1:1]};
            end
        end
    end

    // Accumulator and the operand held for the whole iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else begin
            acc <= acc_next;
            if (load) begin
                opnd     <= is_div ? b_mag : a_mag;
                div_mode <= is_div;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, handshakes, sign handling and result
// selection around the iterative muldiv_core datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MD_XLEN,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    logic [4:0]        rd_q;
    logic              sign_diff_q;
    logic              a_neg_q;
    logic              div_zero_q;
    logic              ovf_q;
    logic [XLEN-1:0]   a_raw_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              load, step;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_result;

    assign in_ready = (state == StIdle);
    assign load     = (state == StIdle) && in_valid && !flush;
    assign step     = (state == StCalc) && !flush;

    // Operand sign classification and magnitudes for the incoming request
    always_comb begin
        a_signed = (in_op == OpMulh) || (in_op == OpMulhsu) || (in_op == OpDiv) || (in_op == OpRem);
        b_signed = (in_op == OpMulh) || (in_op == OpDiv) || (in_op == OpRem);
        a_neg    = a_signed && in_a[XLEN-1];
        b_neg    = b_signed && in_b[XLEN-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
    end

    muldiv_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .is_div(in_op[2]),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .acc   (acc)
    );

    // Sign fix-up, special-case override and result select
    always_comb begin
        prod_s = sign_diff_q ? -acc : acc;
        quo_s  = sign_diff_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (div_zero_q) begin
            quo_s = XLEN'(ALL_ONES);
            rem_s = a_raw_q;
        end else if (ovf_q) begin
            quo_s = XLEN'(INT_MIN);
            rem_s = '0;
        end
        case (op_q)
            OpMul:                      fix_result = prod_s[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  fix_result = prod_s[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              fix_result = quo_s;
            default:                    fix_result = rem_s;
        endcase
    end

    // Control FSM with registered outputs. DONE spends one edge raising
    // out_valid so every result appears exactly 34 edges after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            cnt         <= '0;
            op_q        <= OpMul;
            rd_q        <= '0;
            sign_diff_q <= 1'b0;
            a_neg_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            a_raw_q     <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
        end else if (flush) begin
            state     <= StIdle;
            out_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        op_q        <= op_e'(in_op);
                        rd_q        <= in_rd;
                        sign_diff_q <= a_neg ^ b_neg;
                        a_neg_q     <= a_neg;
                        div_zero_q  <= (in_b == '0);
                        ovf_q       <= ((in_op == OpDiv) || (in_op == OpRem)) &&
                                       (in_a == XLEN'(INT_MIN)) && (in_b == XLEN'(ALL_ONES));
                        a_raw_q     <= in_a;
                        cnt         <= '0;
                        state       <= StCalc;
                    end
                end
                StCalc: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    out_result <= fix_result;
                    out_rd     <= rd_q;
                    state      <= StDone;
                end
                StDone: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a
// monitor pops and compares whenever out_valid rises.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    muldiv_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_rd    (out_rd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare each new result against the head of the scoreboard
    initial begin
        exp_t e;
        bit   seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got result 0x%0h rd %0d, expected none",
                             out_result, out_rd);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, {32'd0, out_result}, {32'd0, e.result});
                    check({e.name, "_rd"}, {59'd0, out_rd}, {59'd0, e.rd});
                    check({e.name, "_latency"}, 64'(cycle - e.acc_cyc), 64'd34);
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    // Present one request for a single edge; optionally record its expectation
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit push,
                         input logic [31:0] exp_res);
        @(negedge clk);
        check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        if (push) sb.push_back('{result: exp_res, rd: rd, acc_cyc: cycle + 1, name: name});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bounded wait until the scoreboard drains and the output is released
    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got pending %0d, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
        issue(name, op, a, b, rd, 1'b1, exp_res);
        drain(name);
    endtask

    // Watch that no output appears for a number of cycles
    task automatic quiet(input string name, input int cycles);
        bit stray = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        check(name, {63'd0, stray}, 64'd0);
    endtask

    initial begin
        bit got;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_result", {32'd0, out_result}, 64'd0);
        check("reset_out_rd", {59'd0, out_rd}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors with hand-computed results
        run("mul_7x6",      3'd0, 32'd7,        32'd6,        5'd3,  32'd42);
        run("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
        run("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
        run("mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF, 32'd2,        5'd6,  32'hFFFF_FFFF);
        run("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFD);
        run("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,        5'd8,  32'hFFFF_FFFF);
        run("divu_100_7",   3'd5, 32'd100,      32'd7,        5'd9,  32'd14);
        run("remu_100_7",   3'd7, 32'd100,      32'd7,        5'd10, 32'd2);
        run("rem_7_m2",     3'd6, 32'd7,        32'hFFFF_FFFE, 5'd11, 32'd1);
        run("divu_5_0",     3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFF_FFFF);
        run("rem_5_0",      3'd6, 32'd5,        32'd0,        5'd13, 32'd5);
        run("div_m7_0",     3'd4, 32'hFFFF_FFF9, 32'd0,        5'd14, 32'hFFFF_FFFF);
        run("rem_m7_0",     3'd6, 32'hFFFF_FFF9, 32'd0,        5'd15, 32'hFFFF_FFF9);
        run("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
        run("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        issue("bp_divu", 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check("bp_valid_seen", {63'd0, got}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {26'd0, out_valid, in_ready, out_rd, out_result},
                  {26'd0, 1'b1, 1'b0, 5'd9, 32'd14});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        drain("bp");

        // Flush in CALC cycle 10 drops the operation
        issue("flush_op", 3'd0, 32'd1000, 32'd1000, 5'd20, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        quiet("flush_quiet", 45);

        // Asynchronous reset mid-CALC drops the operation and clears outputs
        issue("rst_op", 3'd4, 32'd100, 32'd7, 5'd21, 1'b0, 32'd0);
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst", {25'd0, out_valid, in_ready, out_rd, out_result},
              {25'd0, 1'b0, 1'b1, 5'd0, 32'd0});
        @(negedge clk);
        rst = 1'b1;
        quiet("rst_quiet", 45);

        run("mul_3x3", 3'd0, 32'd3, 32'd3, 5'd22, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
